// File: rtl/risc_fetch_unit.sv
// risc_fetch_unit: prefetching fetch stage with a DEPTH-entry {ir,pc} buffer and branch redirect.
// The buffer is a shift register so the head entry is always slot 0.
module risc_fetch_unit #(
  parameter int PC_W = 5,
  parameter int IR_W = 13,
  parameter int DEPTH = 2,
  parameter logic [PC_W-1:0] PC_LAST = '1,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [IR_W-1:0] NOP = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IR_W-1:0] imem_rdata,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  output logic [IR_W-1:0] ir,
  output logic [PC_W-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            ir_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PC_W-1:0] fetch_pc, inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [IR_W-1:0] buf_ir [DEPTH];
  logic [PC_W-1:0] buf_pc [DEPTH];
  logic            pop, push;
  logic [CW:0]     occ;
  logic [AW-1:0]   wr_idx;
  assign imem_addr = fetch_pc;
  always_comb begin
    ir_valid = !rst && count != '0;
    ir = ir_valid ? buf_ir[0] : NOP;
    ir_pc = ir_valid ? buf_pc[0] : '0;
    pop = ir_valid && ir_ready;
    push = inflight && !br_valid;
    occ = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    imem_req = !rst && !br_valid && occ < (CW+1)'(DEPTH);
    wr_idx = AW'(count - CW'(pop));
  end
  // a response arriving during a redirect is dropped because push is gated by br_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      inflight_pc <= fetch_pc;
      if (br_valid) fetch_pc <= br_target;
      else if (imem_req) fetch_pc <= fetch_pc == PC_LAST ? '0 : fetch_pc + 1'b1;
      count <= br_valid ? '0 : count + CW'(push) - CW'(pop);
      if (pop)
        for (int i = 0; i < DEPTH - 1; i++) begin
          buf_ir[i] <= buf_ir[i+1];
          buf_pc[i] <= buf_pc[i+1];
        end
      if (push) begin
        buf_ir[wr_idx] <= imem_rdata;
        buf_pc[wr_idx] <= inflight_pc;
      end
    end
  end
endmodule

// File: tb/tb_risc_fetch_unit.sv
// tb_risc_fetch_unit: vector table, directed corner sequences and a randomized run against a stream model.
// The memory answers each request with addr+0x100, so every instruction word identifies its own pc.
module tb_risc_fetch_unit;
  logic clk = 0, rst = 1, br_valid = 0, ir_ready = 0;
  logic imem_req, ir_valid;
  logic [4:0] imem_addr, ir_pc, br_target = 0;
  logic [12:0] imem_rdata = 0, ir;
  int checks = 0, errors = 0;

  risc_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .br_valid(br_valid), .br_target(br_target), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= imem_req ? 13'(int'(imem_addr) + 256) : 13'($urandom);

  function automatic logic [4:0] nxt(input logic [4:0] a);
    return 5'((int'(a) + 1) % 32);
  endfunction

  function automatic int word(input logic [4:0] a);
    return int'(a) + 256;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic b, input logic [4:0] t, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; br_valid = b; br_target = t; ir_ready = rdy;
    #3;
  endtask

  task automatic expect_ir(input string tag, input logic v, input logic [4:0] pc);
    check({tag, "_valid"}, int'(ir_valid), int'(v));
    check({tag, "_pc"}, int'(ir_pc), v ? int'(pc) : 0);
    check({tag, "_ir"}, int'(ir), v ? word(pc) : 0);
  endtask

  typedef struct {
    logic r, b; logic [4:0] tgt; logic rdy;
    logic ereq; logic [4:0] eaddr; logic eval; logic [4:0] epc;
  } vec_t;
  vec_t tbl [16];

  logic [4:0] hold, exp_pc, nf, held_pc;
  logic [12:0] held_ir;
  logic held;
  int gap;
  logic r, b, rdy;
  logic [4:0] tgt;

  initial begin
    tbl = '{
      '{1, 0, 0, 1, 0, 0, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0, 0},
      '{0, 0, 0, 1, 1, 1, 0, 0},
      '{0, 0, 0, 1, 1, 2, 1, 0},
      '{0, 0, 0, 1, 1, 3, 1, 1},
      '{0, 0, 0, 0, 0, 0, 1, 2},
      '{0, 0, 0, 0, 0, 0, 1, 2},
      '{0, 0, 0, 0, 0, 0, 1, 2},
      '{0, 0, 0, 1, 1, 4, 1, 2},
      '{0, 0, 0, 1, 1, 5, 1, 3},
      '{0, 0, 0, 1, 1, 6, 1, 4},
      '{0, 1, 20, 1, 0, 0, 1, 5},
      '{0, 0, 0, 1, 1, 20, 0, 0},
      '{0, 0, 0, 1, 1, 21, 0, 0},
      '{0, 0, 0, 1, 1, 22, 1, 20},
      '{0, 0, 0, 1, 1, 23, 1, 21}
    };
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].b, tbl[i].tgt, tbl[i].rdy);
      check($sformatf("vec%0d_req", i), int'(imem_req), int'(tbl[i].ereq));
      if (tbl[i].ereq) check($sformatf("vec%0d_addr", i), int'(imem_addr), int'(tbl[i].eaddr));
      expect_ir($sformatf("vec%0d", i), tbl[i].eval, tbl[i].epc);
    end
    // redirect to the last address while the head is being popped
    cyc(0, 1, 31, 1);
    expect_ir("br31_pop", 1, 22);
    check("br31_req", int'(imem_req), 0);
    cyc(0, 0, 0, 1);
    expect_ir("br31_t1", 0, 0);
    check("br31_addr", int'(imem_addr), 31);
    cyc(0, 0, 0, 1);
    expect_ir("br31_t2", 0, 0);
    cyc(0, 0, 0, 1);
    expect_ir("br31_t3", 1, 31);
    cyc(0, 0, 0, 1);
    expect_ir("br31_t4", 1, 0);
    cyc(0, 0, 0, 1);
    expect_ir("br31_t5", 1, 1);
    // five-cycle stall, release, refill, then redirect with a full buffer
    cyc(0, 0, 0, 0);
    hold = ir_pc;
    expect_ir("stall0", 1, hold);
    for (int k = 1; k < 5; k++) begin
      cyc(0, 0, 0, 0);
      expect_ir($sformatf("stall%0d", k), 1, hold);
      check($sformatf("stall%0d_req", k), int'(imem_req), 0);
    end
    cyc(0, 0, 0, 1);
    expect_ir("release0", 1, hold);
    cyc(0, 0, 0, 1);
    expect_ir("release1", 1, nxt(hold));
    hold = nxt(nxt(hold));
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    expect_ir("full", 1, hold);
    cyc(0, 1, 7, 0);
    expect_ir("br7_t0", 1, hold);
    check("br7_req", int'(imem_req), 0);
    cyc(0, 0, 0, 1);
    expect_ir("br7_t1", 0, 0);
    cyc(0, 0, 0, 1);
    expect_ir("br7_t2", 0, 0);
    cyc(0, 0, 0, 1);
    expect_ir("br7_t3", 1, 7);
    cyc(0, 0, 0, 1);
    expect_ir("br7_t4", 1, 8);
    // wrap through PC_LAST with no bubble
    cyc(0, 1, 29, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1);
      expect_ir($sformatf("wrap%0d", k), 1, 5'((29 + k) % 32));
    end
    // reset wins over a simultaneous redirect
    cyc(1, 1, 9, 1);
    expect_ir("rstbr_t0", 0, 0);
    check("rstbr_req", int'(imem_req), 0);
    cyc(0, 0, 0, 1);
    expect_ir("rstbr_t1", 0, 0);
    check("rstbr_req1", int'(imem_req), 1);
    check("rstbr_addr", int'(imem_addr), 0);
    cyc(0, 0, 0, 1);
    expect_ir("rstbr_t2", 0, 0);
    cyc(0, 0, 0, 1);
    expect_ir("rstbr_t3", 1, 0);
    // randomized run: delivered pcs must be a consecutive wrapping stream from the last redirect/reset
    cyc(1, 0, 0, 0);
    exp_pc = 0; nf = 0; held = 0; gap = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom % 100) < 1;
      b = ($urandom % 100) < 5;
      tgt = 5'($urandom);
      rdy = ($urandom % 100) < 70;
      cyc(r, b, tgt, rdy);
      if (r || b) check("rnd_req_blocked", int'(imem_req), 0);
      if (r) expect_ir("rnd_rst", 0, 0);
      if (held && !r) begin
        check("rnd_hold_valid", int'(ir_valid), 1);
        check("rnd_hold_pc", int'(ir_pc), int'(held_pc));
        check("rnd_hold_ir", int'(ir), int'(held_ir));
      end
      if (imem_req) begin
        check("rnd_addr", int'(imem_addr), int'(nf));
        nf = nxt(nf);
      end
      if (!r && ir_valid && rdy) begin
        check("rnd_order", int'(ir_pc), int'(exp_pc));
        check("rnd_data", int'(ir), word(ir_pc));
        exp_pc = nxt(exp_pc);
      end
      gap = (r || b || ir_valid) ? 0 : gap + 1;
      check("rnd_gap_bound", int'(gap <= 2), 1);
      if (r) begin
        exp_pc = 0; nf = 0;
      end else if (b) begin
        exp_pc = tgt; nf = tgt;
      end
      held = !r && !b && ir_valid && !rdy;
      held_pc = ir_pc;
      held_ir = ir;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/risc_fetch_unit.md
RISC_FETCH_UNIT -- requirements
Module: risc_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 5, meaning program counter width in bits.
REQ-002 SHALL have parameter IR_W, default 13, meaning instruction width in bits.
REQ-003 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries (legal range 2..8).
REQ-004 SHALL have parameter PC_LAST, default 2^PC_W-1, meaning highest fetch address before wrap.
REQ-005 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-006 SHALL have parameter NOP, default all-zero IR_W value, meaning no-operation encoding.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port imem_req, output, 1, fetch request to instruction memory this cycle.
REQ-010 SHALL have port imem_addr, output, PC_W, fetch address, valid when imem_req=1.
REQ-011 SHALL have port imem_rdata, input, IR_W, instruction word, valid exactly one cycle after imem_req=1.
REQ-012 SHALL have port br_valid, input, 1, redirect request from later pipeline stage.
REQ-013 SHALL have port br_target, input, PC_W, redirect address, sampled when br_valid=1.
REQ-014 SHALL have port ir, output, IR_W, instruction presented to decode.
REQ-015 SHALL have port ir_pc, output, PC_W, address of the instruction on ir.
REQ-016 SHALL have port ir_valid, output, 1, ir/ir_pc hold a real instruction.
REQ-017 SHALL have port ir_ready, input, 1, decode accepts ir this cycle; transfer when ir_valid & ir_ready.

Function
REQ-018 SHALL keep a DEPTH-entry FIFO of {instruction, pc} pairs; ir/ir_pc driven from the head entry register.
REQ-019 SHALL drive ir=NOP, ir_pc=0, ir_valid=0 whenever the FIFO is empty.
REQ-020 SHALL drive imem_addr from the internal fetch_pc register.
REQ-021 SHALL assert imem_req when not in reset, br_valid=0, and (count + inflight - pop) < DEPTH, where pop = ir_valid & ir_ready and inflight = imem_req of previous cycle not cancelled.
REQ-022 SHALL, on each issued request, advance fetch_pc by 1, wrapping PC_LAST -> 0.
REQ-023 SHALL write {imem_rdata, issued address} into the FIFO tail on the cycle after an uncancelled request.
REQ-024 SHALL give request-to-ir_valid latency of 2 cycles (req cycle t, data cycle t+1, ir_valid at t+2).
REQ-025 SHALL sustain one instruction per cycle with DEPTH=2 while ir_ready=1 continuously.
REQ-026 SHALL hold ir/ir_pc stable while ir_valid=1 and ir_ready=0; FIFO never overflows and never drops a response.
REQ-027 SHALL support simultaneous push and pop in one cycle, count unchanged.
REQ-028 SHALL, when br_valid=1: complete any handshake in that cycle, empty the FIFO, cancel the in-flight response (not written), deassert imem_req, and load fetch_pc <= br_target.
REQ-029 SHALL issue the first request at br_target in cycle t+1 after redirect cycle t, giving ir_valid at t+3.
REQ-030 SHALL treat br_valid on consecutive cycles as successive redirects; the last target wins.
REQ-031 SHALL wrap br_target+1 normally when br_target = PC_LAST.

Reset
REQ-032 SHALL, while rst=1 at a rising edge: fetch_pc <= RESET_PC, FIFO count <= 0, in-flight flag <= 0.
REQ-033 SHALL hold imem_req=0, ir=NOP, ir_pc=0, ir_valid=0 during any cycle rst=1.
REQ-034 SHALL give rst priority over br_valid and over any arriving imem_rdata; mid-stream reset discards all buffered and in-flight instructions.
REQ-035 SHALL issue imem_req with imem_addr=RESET_PC in the first cycle after rst falls.

Verification
REQ-036 Reset release, ir_ready=1, memory returns addr+0x100 -> cycle 0 req addr 0, cycle 2 ir=0x100 ir_pc=0, then one new instruction per cycle.
REQ-037 Run to PC_LAST=31 (defaults) -> ir_pc sequence 30, 31, 0, 1 with no gap.
REQ-038 ir_ready=0 for 5 cycles in steady state -> ir/ir_pc frozen, imem_req low after FIFO full, no lost or duplicated pc on release.
REQ-039 br_valid=1 br_target=7 at cycle t with full FIFO and response in flight -> ir_valid=0 at t+1, t+2; ir_pc=7 at t+3, then 8.
REQ-040 rst pulsed one cycle mid-stream with br_valid=1 same cycle -> redirect ignored, next fetch at RESET_PC, ir_valid=0 until 2 cycles after release.
REQ-041 Redirect with br_target=31 and pop in same cycle -> popped instruction counted once, subsequent ir_pc 31, 0.
